shift_arbiter: RTL and testbench
================================

# shift_arbiter

Two-requester front end for the core's shared 32-bit barrel shifter. It arbitrates between two valid/ready requesters, drives the combinational shifter with the winning operand, shift amount and command, and captures the result in a one-entry output register with valid/ready back-pressure. Typical requesters are the integer execute lane (port 0) and the load/store alignment path (port 1).

## Interface

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority to port 0 with a starvation guard.
- STARVE_MAX, 4: used only when RR_EN = 0. Number of consecutive port-1 losses after which port 1 is forced to win. Legal range 1..15.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset_n  in  1  Reset, synchronous, active-low.
- flush_i  in  1  Discards the output register contents; blocks acceptance this cycle.
- req0_valid_i  in  1  Port 0 request valid.
- req0_ready_o  out  1  Port 0 accepted this cycle.
- req0_data_i  in  32  Port 0 operand.
- req0_shamt_i  in  5  Port 0 shift amount.
- req0_cmd_i  in  2  Port 0 command: 00 = SLL, 01 = SRL, 1x = SRA.
- req0_tag_i  in  4  Port 0 opaque tag, returned with the result.
- req1_valid_i, req1_ready_o, req1_data_i, req1_shamt_i, req1_cmd_i, req1_tag_i: same as port 0, for port 1.
- rsp_valid_o  out  1  Result register holds a valid result.
- rsp_ready_i  in  1  Consumer takes the result.
- rsp_data_o  out  32  Shift result.
- rsp_src_o  out  1  Winning port index, 0 or 1.
- rsp_tag_o  out  4  Tag of the winning request.

## Operation

- slot_free = !rsp_valid_o | rsp_ready_i. Acceptance is possible only when slot_free & !flush_i & reset_n.
- Grant is combinational:
  - Only one port valid: that port wins.
  - Both ports valid, RR_EN = 1: the port not recorded in last_grant wins.
  - Both ports valid, RR_EN = 0: port 0 wins, unless starve_cnt == STARVE_MAX, in which case port 1 wins.
- reqN_ready_o = acceptance possible & grant == N. At most one ready is high per cycle. Ready never depends on reqN_valid_i of the other port through a loop.
- On acceptance:
  - Drive the shifter with the winner's data, shamt and cmd.
  - Register the result, the winner index and the winner's tag.
  - Set rsp_valid_o.
  - last_grant <= winner.
- When rsp_ready_i & rsp_valid_o and there is no acceptance, clear rsp_valid_o. Data and tag hold their last value.
- Starvation counter (RR_EN = 0 only), 4 bits:
  - Increments on each acceptance of port 0 while req1_valid_i is high.
  - Clears on any acceptance of port 1.
  - Saturates at STARVE_MAX.
  - Otherwise holds.
- Requester rule: once valid is high, data, shamt, cmd and tag must stay stable until ready. The bench asserts this.
- flush_i:
  - rsp_valid_o = 0 the next cycle.
  - Both readies are low during the flush cycle.
  - last_grant and starve_cnt are unchanged.
- Arithmetic: shamt uses all 5 bits, so shifts of 0..31. For SRA, vacated bits copy bit 31 of the operand. cmd 11 behaves exactly as 10.

## Timing

- Latency: acceptance in cycle N gives rsp_valid_o with the result in cycle N+1.
- Throughput: one result per cycle while rsp_ready_i stays high.
- Back-pressure: with rsp_valid_o = 1 and rsp_ready_i = 0, both readies are low, and rsp_data_o, rsp_src_o and rsp_tag_o are held stable.
- Simultaneous drain and accept in one cycle: the register is overwritten with the new result and rsp_valid_o stays 1 (no bubble).
- Reset values, applied on the clk edge where reset_n = 0:
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_src_o = 0, rsp_tag_o = 0.
  - last_grant = 1, so port 0 wins the first contested round.
  - starve_cnt = 0.
  - While reset_n = 0, both readies are 0.
- Reset in mid-operation drops any held result. A requester whose request was not accepted keeps it pending and is served after reset.

## Test plan

- Single shifts on port 0, rsp_ready_i = 1:
  - data 0x8000_0001, shamt 4: SLL gives 0x0000_0010, SRL gives 0x0800_0000, SRA gives 0xF800_0000.
  - Each result appears one cycle after acceptance, with rsp_src_o = 0.
- RR_EN = 1, both ports valid continuously for 6 cycles, tags 0xA (port 0) and 0x5 (port 1):
  - rsp_src_o sequence is 0,1,0,1,0,1 with matching tags.
- RR_EN = 0, STARVE_MAX = 4, both ports valid continuously:
  - rsp_src_o sequence is 0,0,0,0,1,0,0,0,0,1.
- Back-pressure: hold rsp_ready_i = 0 for 3 cycles after a result of 0x1234_0000.
  - Output stays stable and both readies stay low.
  - Raise rsp_ready_i while port 1 is valid: the next result is accepted the same cycle, with no gap in rsp_valid_o.
- flush_i asserted while rsp_valid_o = 1 and port 0 is valid:
  - rsp_valid_o = 0 the next cycle.
  - req0_ready_o stays low during the flush cycle.
  - Port 0 is accepted the following cycle.
- Reset asserted for 1 cycle mid-stream:
  - All outputs read 0 after the reset edge.
  - The first contested grant after reset goes to port 0.
  - Edge values: shamt 0 returns the operand unchanged; shamt 31 SRA of 0x8000_0000 gives 0xFFFF_FFFF.

Source files
------------

// File: rtl/shift_arbiter.sv
// Purpose : two-port valid/ready arbiter in front of a shared 32-bit barrel shifter.
// Latency : 1 cycle, from request acceptance to rsp_valid_o with the result.
// Backpressure: a held result (rsp_valid_o & !rsp_ready_i) or flush_i drops both request readies.
//
// Ports:
//   clk, reset_n       single clock, synchronous active-low reset
//   flush_i            discard the held result, no acceptance this cycle
//   reqN_*             requester N: valid/ready, operand, shift amount, command, tag
//                      (cmd 00 = SLL, 01 = SRL, 1x = SRA)
//   rsp_*              one-entry result register: valid/ready, data, source port, tag
//
// Parameters:
//   RR_EN       1 = round-robin, 0 = fixed priority to port 0 with starvation guard
//   STARVE_MAX  consecutive port-1 losses before port 1 is forced to win (1..15)

module shift_arbiter #(
  parameter int RR_EN      = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [1:0]  req0_cmd_i,
  input  logic [3:0]  req0_tag_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data_i,
  input  logic [4:0]  req1_shamt_i,
  input  logic [1:0]  req1_cmd_i,
  input  logic [3:0]  req1_tag_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_src_o,
  output logic [3:0]  rsp_tag_o
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  cmd;
    logic [3:0]  tag;
  } req_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Arbitration state
  logic       last_grant;
  logic [3:0] starve_cnt;

  // Combinational arbitration / datapath
  logic        slot_free;
  logic        accept_ok;
  logic        grant;
  logic        fire;
  req_t        req0;
  req_t        req1;
  req_t        win;
  logic [31:0] shift_res;

  assign req0 = '{data: req0_data_i, shamt: req0_shamt_i, cmd: req0_cmd_i, tag: req0_tag_i};
  assign req1 = '{data: req1_data_i, shamt: req1_shamt_i, cmd: req1_cmd_i, tag: req1_tag_i};

  // The result register can take a new entry when empty or being drained
  // in the same cycle; flush and reset both block acceptance.
  assign slot_free = !rsp_valid_o | rsp_ready_i;
  assign accept_ok = slot_free & !flush_i & reset_n;

  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && !req1_valid_i) begin
      grant = 1'b0;
    end else if (req1_valid_i && !req0_valid_i) begin
      grant = 1'b1;
    end else if (req0_valid_i && req1_valid_i) begin
      if (RR_EN != 0) begin
        grant = ~last_grant;
      end else begin
        // Port 0 owns the shifter until port 1 has lost STARVE_MAX times in a row.
        grant = (starve_cnt == STARVE_LIM);
      end
    end
  end

  // Each ready depends on the other port's valid only through the grant
  // decision, never on its own ready, so there is no combinational loop.
  assign req0_ready_o = accept_ok & ~grant;
  assign req1_ready_o = accept_ok &  grant;

  assign fire = (req0_ready_o & req0_valid_i) | (req1_ready_o & req1_valid_i);
  assign win  = grant ? req1 : req0;

  // Barrel shifter; cmd 11 is treated exactly like 10 (arithmetic right).
  always_comb begin
    shift_res = '0;
    case (win.cmd)
      2'b00:   shift_res = win.data << win.shamt;
      2'b01:   shift_res = win.data >> win.shamt;
      default: shift_res = 32'($signed(win.data) >>> win.shamt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_src_o   <= 1'b0;
      rsp_tag_o   <= '0;
      last_grant  <= 1'b1;   // port 0 wins the first contested round
      starve_cnt  <= '0;
    end else begin
      if (fire) begin
        // Overwrites a result being drained this cycle: no bubble.
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= shift_res;
        rsp_src_o   <= grant;
        rsp_tag_o   <= win.tag;
        last_grant  <= grant;
      end else if (flush_i) begin
        rsp_valid_o <= 1'b0;
      end else if (rsp_valid_o && rsp_ready_i) begin
        // Data/src/tag intentionally keep their last value.
        rsp_valid_o <= 1'b0;
      end

      if (RR_EN == 0) begin
        if (fire && grant) begin
          starve_cnt <= '0;
        end else if (fire && !grant && req1_valid_i && (starve_cnt != STARVE_LIM)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose : directed self-checking bench for shift_arbiter (round-robin and fixed-priority builds).
// Latency : results checked one clk after the accepting edge.
// Backpressure: exercised via rsp_ready_i low, flush_i and mid-stream reset.

module tb_shift_arbiter;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        v0, v1;
  logic [31:0] d0, d1;
  logic [4:0]  s0, s1;
  logic [1:0]  c0, c1;
  logic [3:0]  t0, t1;
  logic        rsp_rdy;

  // Round-robin instance outputs
  logic        r_rdy0, r_rdy1, r_vld, r_src;
  logic [31:0] r_dat;
  logic [3:0]  r_tag;
  // Fixed-priority instance outputs
  logic        f_rdy0, f_rdy1, f_vld, f_src;
  logic [31:0] f_dat;
  logic [3:0]  f_tag;

  int n_cmp = 0;
  int n_bad = 0;

  shift_arbiter #(.RR_EN(1), .STARVE_MAX(4)) u_rr (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .req0_valid_i(v0), .req0_ready_o(r_rdy0), .req0_data_i(d0), .req0_shamt_i(s0),
    .req0_cmd_i(c0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(r_rdy1), .req1_data_i(d1), .req1_shamt_i(s1),
    .req1_cmd_i(c1), .req1_tag_i(t1),
    .rsp_valid_o(r_vld), .rsp_ready_i(rsp_rdy), .rsp_data_o(r_dat),
    .rsp_src_o(r_src), .rsp_tag_o(r_tag)
  );

  shift_arbiter #(.RR_EN(0), .STARVE_MAX(4)) u_fp (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .req0_valid_i(v0), .req0_ready_o(f_rdy0), .req0_data_i(d0), .req0_shamt_i(s0),
    .req0_cmd_i(c0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(f_rdy1), .req1_data_i(d1), .req1_shamt_i(s1),
    .req1_cmd_i(c1), .req1_tag_i(t1),
    .rsp_valid_o(f_vld), .rsp_ready_i(rsp_rdy), .rsp_data_o(f_dat),
    .rsp_src_o(f_src), .rsp_tag_o(f_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("mismatch on %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; rsp_rdy = 1'b1;
    v0 = 1'b0; d0 = '0; s0 = '0; c0 = '0; t0 = '0;
    v1 = 1'b0; d1 = '0; s1 = '0; c1 = '0; t1 = '0;

    // ---- Reset state ----
    step();
    chk("rst_vld", r_vld, 0);
    chk("rst_dat", r_dat, 0);
    chk("rst_src", r_src, 0);
    chk("rst_tag", r_tag, 0);
    chk("rst_rdy0", r_rdy0, 0);
    chk("rst_fp_vld", f_vld, 0);

    // ---- Round-robin, both ports valid for 6 cycles ----
    reset_n = 1'b1;
    v0 = 1'b1; d0 = 32'h0000_0001; s0 = 5'd0; c0 = 2'b00; t0 = 4'hA;
    v1 = 1'b1; d1 = 32'h0000_0002; s1 = 5'd0; c1 = 2'b00; t1 = 4'h5;
    #1;
    chk("rr_first_rdy0", r_rdy0, 1);
    chk("rr_first_rdy1", r_rdy1, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_src_%0d", i), r_src, (i % 2));
      chk($sformatf("rr_tag_%0d", i), r_tag, (i % 2) ? 4'h5 : 4'hA);
      chk($sformatf("rr_dat_%0d", i), r_dat, (i % 2) ? 32'h2 : 32'h1);
    end

    // ---- Single shifts on port 0 ----
    v1 = 1'b0;
    d0 = 32'h8000_0001; s0 = 5'd4; c0 = 2'b00; t0 = 4'h3;
    #1;
    chk("p0_rdy", r_rdy0, 1);
    step();
    chk("sll_dat", r_dat, 32'h0000_0010);
    chk("sll_src", r_src, 0);
    chk("sll_tag", r_tag, 4'h3);
    chk("sll_vld", r_vld, 1);
    c0 = 2'b01;
    step();
    chk("srl_dat", r_dat, 32'h0800_0000);
    c0 = 2'b10;
    step();
    chk("sra_dat", r_dat, 32'hF800_0000);
    c0 = 2'b11;
    step();
    chk("sra11_dat", r_dat, 32'hF800_0000);
    d0 = 32'hDEAD_BEEF; s0 = 5'd0; c0 = 2'b00;
    step();
    chk("shamt0_dat", r_dat, 32'hDEAD_BEEF);
    d0 = 32'h8000_0000; s0 = 5'd31; c0 = 2'b10;
    step();
    chk("sra31_dat", r_dat, 32'hFFFF_FFFF);
    c0 = 2'b01;
    step();
    chk("srl31_dat", r_dat, 32'h0000_0001);

    // ---- Back-pressure ----
    d0 = 32'h0000_1234; s0 = 5'd16; c0 = 2'b00; t0 = 4'h7;
    step();
    chk("bp_dat", r_dat, 32'h1234_0000);
    rsp_rdy = 1'b0;
    v0 = 1'b0;
    v1 = 1'b1; d1 = 32'h0000_00FF; s1 = 5'd8; c1 = 2'b00; t1 = 4'h9;
    #1;
    chk("bp_rdy0", r_rdy0, 0);
    chk("bp_rdy1", r_rdy1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_vld_%0d", i), r_vld, 1);
      chk($sformatf("bp_hold_dat_%0d", i), r_dat, 32'h1234_0000);
      chk($sformatf("bp_hold_tag_%0d", i), r_tag, 4'h7);
      chk($sformatf("bp_hold_src_%0d", i), r_src, 0);
      chk($sformatf("bp_hold_rdy1_%0d", i), r_rdy1, 0);
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy1", r_rdy1, 1);
    step();
    chk("bp_next_vld", r_vld, 1);
    chk("bp_next_dat", r_dat, 32'h0000_FF00);
    chk("bp_next_src", r_src, 1);
    chk("bp_next_tag", r_tag, 4'h9);

    // ---- Flush while a result is held and port 0 is valid ----
    v1 = 1'b0;
    v0 = 1'b1; d0 = 32'h0000_000F; s0 = 5'd4; c0 = 2'b00; t0 = 4'h2;
    flush = 1'b1;
    #1;
    chk("flush_rdy0", r_rdy0, 0);
    step();
    chk("flush_vld", r_vld, 0);
    flush = 1'b0;
    #1;
    chk("post_flush_rdy0", r_rdy0, 1);
    step();
    chk("post_flush_vld", r_vld, 1);
    chk("post_flush_dat", r_dat, 32'h0000_00F0);
    chk("post_flush_tag", r_tag, 4'h2);

    // ---- Reset mid-stream with both requesters pending ----
    d0 = 32'h0000_0005; s0 = 5'd1; c0 = 2'b00; t0 = 4'h4;
    v1 = 1'b1; d1 = 32'hFFFF_0000; s1 = 5'd4; c1 = 2'b10; t1 = 4'hC;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy0", r_rdy0, 0);
    chk("mid_rst_rdy1", r_rdy1, 0);
    step();
    chk("mid_rst_vld", r_vld, 0);
    chk("mid_rst_dat", r_dat, 0);
    chk("mid_rst_src", r_src, 0);
    chk("mid_rst_tag", r_tag, 0);
    chk("mid_rst_fp_vld", f_vld, 0);
    chk("mid_rst_fp_dat", f_dat, 0);
    reset_n = 1'b1;
    #1;
    chk("after_rst_rr_rdy0", r_rdy0, 1);
    chk("after_rst_fp_rdy0", f_rdy0, 1);

    // ---- Fixed priority with starvation guard, both valid continuously ----
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("fp_src_%0d", i), f_src, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("fp_dat_%0d", i), f_dat, (i % 5 == 4) ? 32'hFFFF_F000 : 32'h0000_000A);
      chk($sformatf("fp_tag_%0d", i), f_tag, (i % 5 == 4) ? 4'hC : 4'h4);
      if (i == 0) chk("after_rst_rr_src", r_src, 0);
    end

    v0 = 1'b0; v1 = 1'b0;
    step();
    chk("drain_vld", f_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
